// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction
// fetch (I) and the load/store path (D). D wins contention, but a streak
// limiter forces I in after MAX_D_STREAK consecutive contended D grants.
// Addresses are word-aligned on issue, and a misaligned address or a
// memory response timeout raises a sticky error.
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t     state;
    owner_t     owner;
    logic [3:0] streak;
    logic [7:0] tcnt;

    logic       streak_full;
    logic       grant_d;
    logic       grant_i;

    // Grant decision for the current IDLE cycle: D first unless the streak is exhausted
    always_comb begin
        streak_full = (streak == 4'(MAX_D_STREAK));
        grant_d     = 1'b0;
        grant_i     = 1'b0;
        if (d_req && !(i_req && streak_full))
            grant_d = 1'b1;
        else if (i_req)
            grant_i = 1'b1;
    end

    // Port FSM with registered memory-side and requester-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            streak    <= '0;
            tcnt      <= '0;
            i_done    <= 1'b0;
            i_rdata   <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= BUSY;
                        owner     <= OWN_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= {d_addr[31:2], 2'b00};
                        mem_wdata <= d_wdata;
                        tcnt      <= '0;
                        // streak only counts D grants that actually held I off
                        if (i_req)
                            streak <= streak + 4'd1;
                        if (d_addr[1:0] != 2'b00 && !err) begin
                            err      <= 1'b1;
                            err_code <= 2'b10;
                        end
                    end else if (grant_i) begin
                        state     <= BUSY;
                        owner     <= OWN_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {i_addr[31:2], 2'b00};
                        mem_wdata <= '0;
                        tcnt      <= '0;
                        streak    <= '0;
                        if (i_addr[1:0] != 2'b00 && !err) begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (owner == OWN_D) begin
                            d_rdata <= mem_rdata;
                            d_done  <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_done  <= 1'b1;
                        end
                    end else if (tcnt == 8'(TIMEOUT - 1)) begin
                        // abort: requester still gets its resume pulse, with zero data
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (owner == OWN_D) begin
                            d_rdata <= '0;
                            d_done  <= 1'b1;
                        end else begin
                            i_rdata <= '0;
                            i_done  <= 1'b1;
                        end
                        if (!err) begin
                            err      <= 1'b1;
                            err_code <= 2'b11;
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                RESP: begin
                    // done is visible this cycle; requests are not sampled here
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
